// File: rtl/kernel_sched.sv
// kernel_sched: layer-level sequencer for the kernel weight path.
// Takes one layer descriptor at a time, opens the kernel write window,
// tracks the weight stream until the programmed beat count has landed,
// then opens the kernel read window once per pass while counting consumed
// kernel words. Every output is a flop, decoded from the next state.
module kernel_sched #(
    parameter int unsigned           CFG_DWIDTH = 32,
    parameter int unsigned           CFG_AWIDTH = 5,
    parameter int unsigned           MEM_AWIDTH = 16,
    parameter int unsigned           BEAT_WIDTH = 24,
    parameter int unsigned           PASS_WIDTH = 16,
    parameter int unsigned           ARM_LAT    = 2,
    parameter logic [CFG_AWIDTH-1:0] CFG_KER_WR = 5'd4,
    parameter logic [CFG_AWIDTH-1:0] CFG_KER_RD = 5'd5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MEM_AWIDTH-1:0] desc_wr_end,
    input  logic [MEM_AWIDTH-1:0] desc_rd_start,
    input  logic [MEM_AWIDTH-1:0] desc_rd_end,
    input  logic [BEAT_WIDTH-1:0] desc_beats,
    input  logic [PASS_WIDTH-1:0] desc_passes,
    input  logic                  desc_val,
    output logic                  desc_rdy,
    output logic [CFG_DWIDTH-1:0] cfg_data,
    output logic [CFG_AWIDTH-1:0] cfg_addr,
    output logic                  cfg_valid,
    input  logic                  str_ker_val,
    input  logic                  str_ker_rdy,
    input  logic                  kernel_rdy,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned ARM_W = (ARM_LAT > 1) ? $clog2(ARM_LAT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CFG_WR,
        LOAD,
        CFG_RD,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;
    state_t after_load;

    // Latched descriptor
    logic [MEM_AWIDTH-1:0] wr_end_q,   wr_end_d;
    logic [MEM_AWIDTH-1:0] rd_start_q, rd_start_d;
    logic [MEM_AWIDTH-1:0] rd_end_q,   rd_end_d;
    logic [BEAT_WIDTH-1:0] beats_q,    beats_d;
    logic [PASS_WIDTH-1:0] passes_q,   passes_d;

    // Progress counters
    logic [BEAT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [PASS_WIDTH-1:0] pass_cnt_q, pass_cnt_d;
    logic [MEM_AWIDTH:0]   rd_cnt_q,   rd_cnt_d;
    logic [ARM_W-1:0]      arm_cnt_q,  arm_cnt_d;

    // Registered outputs
    logic [CFG_DWIDTH-1:0] cfg_data_q,  cfg_data_d;
    logic [CFG_AWIDTH-1:0] cfg_addr_q,  cfg_addr_d;
    logic                  cfg_valid_q, cfg_valid_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;
    logic                  desc_rdy_q,  desc_rdy_d;

    logic                  hs;
    logic                  armed;
    logic [MEM_AWIDTH-1:0] span;
    logic [MEM_AWIDTH:0]   words;

    // Handshake, arming and window-size decode
    always_comb begin
        hs    = str_ker_val & str_ker_rdy;
        armed = (arm_cnt_q == ARM_W'(ARM_LAT));
        // Difference taken at MEM_AWIDTH bits so wrap-around windows fold mod 2^MEM_AWIDTH
        span  = rd_end_q - rd_start_q;
        words = {1'b0, span} + (MEM_AWIDTH + 1)'(1);
        after_load = (passes_q != '0) ? CFG_RD : DONE;
    end

    // Next-state, descriptor latch and counter update
    always_comb begin
        state_d    = state_q;
        wr_end_d   = wr_end_q;
        rd_start_d = rd_start_q;
        rd_end_d   = rd_end_q;
        beats_d    = beats_q;
        passes_d   = passes_q;
        beat_cnt_d = beat_cnt_q;
        pass_cnt_d = pass_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        arm_cnt_d  = arm_cnt_q;

        case (state_q)
            IDLE: begin
                if (desc_val && desc_rdy_q) begin
                    wr_end_d   = desc_wr_end;
                    rd_start_d = desc_rd_start;
                    rd_end_d   = desc_rd_end;
                    beats_d    = desc_beats;
                    passes_d   = desc_passes;
                    beat_cnt_d = '0;
                    pass_cnt_d = '0;
                    rd_cnt_d   = '0;
                    arm_cnt_d  = '0;
                    if (desc_beats != '0) begin
                        state_d = CFG_WR;
                    end else if (desc_passes != '0) begin
                        state_d = CFG_RD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            CFG_WR: begin
                if (hs) begin
                    beat_cnt_d = beat_cnt_q + BEAT_WIDTH'(1);
                end
                state_d = LOAD;
            end

            LOAD: begin
                // A single-beat load may complete during CFG_WR; leaving via LOAD
                // keeps the two window writes on non-adjacent cycles.
                if (beat_cnt_q == beats_q) begin
                    state_d = after_load;
                end else if (hs) begin
                    beat_cnt_d = beat_cnt_q + BEAT_WIDTH'(1);
                    if (beat_cnt_d == beats_q) begin
                        state_d = after_load;
                    end
                end
            end

            CFG_RD: begin
                arm_cnt_d = '0;
                rd_cnt_d  = '0;
                state_d   = RUN;
            end

            RUN: begin
                if (!armed) begin
                    arm_cnt_d = arm_cnt_q + ARM_W'(1);
                end else if (kernel_rdy) begin
                    rd_cnt_d = rd_cnt_q + (MEM_AWIDTH + 1)'(1);
                    if (rd_cnt_d == words) begin
                        pass_cnt_d = pass_cnt_q + PASS_WIDTH'(1);
                        state_d    = (pass_cnt_d == passes_q) ? DONE : CFG_RD;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, registered below
    always_comb begin
        cfg_valid_d = 1'b0;
        cfg_addr_d  = '0;
        cfg_data_d  = '0;
        case (state_d)
            CFG_WR: begin
                cfg_valid_d                   = 1'b1;
                cfg_addr_d                    = CFG_KER_WR;
                cfg_data_d[0 +: MEM_AWIDTH]   = wr_end_d;
            end
            CFG_RD: begin
                cfg_valid_d                              = 1'b1;
                cfg_addr_d                               = CFG_KER_RD;
                cfg_data_d[0 +: MEM_AWIDTH]              = rd_start_d;
                cfg_data_d[CFG_DWIDTH/2 +: MEM_AWIDTH]   = rd_end_d;
            end
            default: begin
            end
        endcase
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        desc_rdy_d = (state_d == IDLE);
    end

    // State, descriptor, counter and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_end_q    <= '0;
            rd_start_q  <= '0;
            rd_end_q    <= '0;
            beats_q     <= '0;
            passes_q    <= '0;
            beat_cnt_q  <= '0;
            pass_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            arm_cnt_q   <= '0;
            cfg_data_q  <= '0;
            cfg_addr_q  <= '0;
            cfg_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            desc_rdy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_end_q    <= wr_end_d;
            rd_start_q  <= rd_start_d;
            rd_end_q    <= rd_end_d;
            beats_q     <= beats_d;
            passes_q    <= passes_d;
            beat_cnt_q  <= beat_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            arm_cnt_q   <= arm_cnt_d;
            cfg_data_q  <= cfg_data_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_valid_q <= cfg_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            desc_rdy_q  <= desc_rdy_d;
        end
    end

    assign cfg_data  = cfg_data_q;
    assign cfg_addr  = cfg_addr_q;
    assign cfg_valid = cfg_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign desc_rdy  = desc_rdy_q;

endmodule

// File: tb/tb_kernel_sched.sv
// Testbench for kernel_sched: randomized descriptors and stream activity,
// with a scoreboard of expected config writes / done pulses and their cycles.
module tb_kernel_sched;

    localparam int ARM_LAT = 2;

    logic        clk;
    logic        rst;
    logic [15:0] desc_wr_end, desc_rd_start, desc_rd_end;
    logic [23:0] desc_beats;
    logic [15:0] desc_passes;
    logic        desc_val;
    logic        desc_rdy;
    logic [31:0] cfg_data;
    logic [4:0]  cfg_addr;
    logic        cfg_valid;
    logic        str_ker_val, str_ker_rdy, kernel_rdy;
    logic        busy, done;

    kernel_sched dut (
        .clk(clk), .rst(rst),
        .desc_wr_end(desc_wr_end), .desc_rd_start(desc_rd_start),
        .desc_rd_end(desc_rd_end), .desc_beats(desc_beats),
        .desc_passes(desc_passes), .desc_val(desc_val), .desc_rdy(desc_rdy),
        .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
        .str_ker_val(str_ker_val), .str_ker_rdy(str_ker_rdy),
        .kernel_rdy(kernel_rdy), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct packed {
        logic        is_done;
        logic [4:0]  addr;
        logic [31:0] data;
    } ev_t;

    ev_t    exp_q[$];
    logic   rst_last = 1'b0;
    longint ncyc = 0;
    bit     active = 0, exp_valid = 0, prev_valid = 0;
    longint exp_cycle = 0, wr_cycle = 0, rd_cycle = 0;
    bit     load_open = 0, rd_open = 0;
    int     beats_seen = 0, words_seen = 0, cur_beats = 0, cur_words = 0;
    int     rd_events = 0;
    bit     str_mode = 0, ker_mode = 0;

    always @(posedge clk) rst_last = rst;

    // Monitor / reference model: sampled on the falling edge
    always @(negedge clk) begin
        ev_t e;
        ncyc++;
        if (!rst_last) begin
            chk("rst_cfg_valid", cfg_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_desc_rdy", desc_rdy, 0);
            chk("rst_cfg_addr", cfg_addr, 0);
            chk("rst_cfg_data", cfg_data, 0);
            exp_q.delete();
            active = 0; exp_valid = 0; prev_valid = 0;
            load_open = 0; rd_open = 0;
        end else begin
            chk("desc_rdy", desc_rdy, !active);
            chk("busy", busy, active);
            if (exp_valid && ncyc > exp_cycle) begin
                chk("late_event", ncyc, exp_cycle);
                exp_valid = 0;
            end
            if (cfg_valid || done) begin
                chk("spurious_event", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("event_kind_done", done, e.is_done);
                    chk("event_cycle", ncyc, exp_valid ? exp_cycle : 0);
                    exp_valid = 0;
                    if (e.is_done) begin
                        chk("done_excl_cfg", cfg_valid, 0);
                        active = 0;
                    end else begin
                        chk("cfg_addr", cfg_addr, e.addr);
                        chk("cfg_data", cfg_data, e.data);
                        chk("cfg_gap", prev_valid, 0);
                        if (e.addr == 5'd4) begin
                            load_open = 1; wr_cycle = ncyc; beats_seen = 0;
                        end else begin
                            rd_open = 1; rd_cycle = ncyc; words_seen = 0; rd_events++;
                        end
                    end
                end
            end
            prev_valid = cfg_valid;
            if (load_open && str_ker_val && str_ker_rdy) begin
                beats_seen++;
                if (beats_seen == cur_beats) begin
                    load_open = 0;
                    exp_cycle = ((ncyc > wr_cycle) ? ncyc : wr_cycle + 1) + 1;
                    exp_valid = 1;
                end
            end
            if (rd_open && ncyc >= rd_cycle + 1 + ARM_LAT && kernel_rdy) begin
                words_seen++;
                if (words_seen == cur_words) begin
                    rd_open = 0;
                    exp_cycle = ncyc + 1;
                    exp_valid = 1;
                end
            end
            if (desc_val && desc_rdy && !active) begin
                cur_beats = int'(desc_beats);
                cur_words = ((int'(desc_rd_end) - int'(desc_rd_start) + 65536) % 65536) + 1;
                if (desc_beats != 0)
                    exp_q.push_back('{is_done: 1'b0, addr: 5'd4, data: {16'h0, desc_wr_end}});
                for (int p = 0; p < int'(desc_passes); p++)
                    exp_q.push_back('{is_done: 1'b0, addr: 5'd5, data: {desc_rd_end, desc_rd_start}});
                exp_q.push_back('{is_done: 1'b1, addr: 5'd0, data: 32'h0});
                active = 1; rd_events = 0;
                exp_cycle = ncyc + 1; exp_valid = 1;
            end
        end
    end

    // Stream and consume-strobe driver
    initial begin
        str_ker_val = 0; str_ker_rdy = 0; kernel_rdy = 0;
        forever begin
            @(posedge clk); #1;
            if (str_mode) begin
                str_ker_val = 1; str_ker_rdy = 1;
            end else begin
                str_ker_val = ($urandom_range(0, 3) != 0);
                str_ker_rdy = ($urandom_range(0, 3) != 0);
            end
            kernel_rdy = ker_mode ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [15:0] wr, input logic [15:0] rs, input logic [15:0] re,
                        input logic [23:0] beats, input logic [15:0] passes);
        bit ok;
        @(posedge clk); #1;
        desc_wr_end = wr; desc_rd_start = rs; desc_rd_end = re;
        desc_beats = beats; desc_passes = passes; desc_val = 1;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (desc_rdy) ok = 1;
        end
        if (!ok) chk("accept_timeout", desc_rdy, 1);
        @(posedge clk); #1;
        desc_val = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!active && exp_q.size() == 0) return;
        end
        chk("idle_timeout", exp_q.size(), 0);
    endtask

    initial begin
        rst = 0; desc_val = 0;
        desc_wr_end = 0; desc_rd_start = 0; desc_rd_end = 0; desc_beats = 0; desc_passes = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;

        // Basic load and two passes, consume strobe held high
        ker_mode = 1; str_mode = 0;
        send(16'd3, 16'd0, 16'd3, 24'd8, 16'd2);
        wait_idle();
        // Load skipped
        ker_mode = 0;
        send(16'd9, 16'd5, 16'd5, 24'd0, 16'd1);
        wait_idle();
        // Load only
        send(16'd7, 16'd0, 16'd0, 24'd3, 16'd0);
        wait_idle();
        // Single beat with stream held high, then minimum descriptor
        str_mode = 1;
        send(16'h1234, 16'd2, 16'd4, 24'd1, 16'd1);
        send(16'd0, 16'd0, 16'd0, 24'd0, 16'd0);
        wait_idle();
        str_mode = 0;
        // Wrap-around window
        send(16'd0, 16'hFFFE, 16'h0001, 24'd2, 16'd1);
        wait_idle();
        // Reset mid-operation during the first of three passes
        send(16'd5, 16'd0, 16'd9, 24'd2, 16'd3);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (rd_events >= 1) break;
        end
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1 rst = 1;
        send(16'd6, 16'd1, 16'd2, 24'd2, 16'd1);
        wait_idle();

        // Randomized descriptors, some issued back-to-back while busy
        for (int n = 0; n < 30; n++) begin
            logic [15:0] rs, span;
            rs   = 16'($urandom);
            span = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom_range(0, 5));
            str_mode = ($urandom_range(0, 3) == 0);
            ker_mode = ($urandom_range(0, 3) == 0);
            send(16'($urandom), rs, rs + span, 24'($urandom_range(0, 6)), 16'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
